// File: rtl/uart_alu_top_if.sv
// ---------------------------------------------------------------------------
// uart_alu_top_if
// Purpose : groups the two UART pin signals of the serial command processor.
// Signals : rx_i - UART receive line (8N1, LSB first, idle high)
//           tx_o - UART transmit line (8N1, LSB first, idle high)
// Modports: slave  - the processor (samples rx_i, drives tx_o)
//           master - the remote UART / bench (drives rx_i, samples tx_o)
// ---------------------------------------------------------------------------
interface uart_alu_top_if;
    logic rx_i;
    logic tx_o;

    modport slave  (input rx_i, output tx_o);
    modport master (output rx_i, input tx_o);
endinterface

// File: rtl/uart_alu_top.sv
// ---------------------------------------------------------------------------
// uart_alu_top
// Purpose : serial command processor. Receives packets over a UART, runs a
//           32-bit wrapping ADD or an ECHO, and returns results over UART TX.
// Ports   : clk_i  - system clock, rising edge
//           rst_ni - asynchronous active-low reset
//           uart   - rx_i / tx_o pin pair (slave modport)
// Params  : ClksPerBit - clock cycles per UART bit
// ---------------------------------------------------------------------------
module uart_alu_top #(
    parameter int ClksPerBit = 410
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_alu_top_if.slave  uart
);
    localparam int CW = $clog2(ClksPerBit + 1);
    localparam logic [CW-1:0] Half = CW'(ClksPerBit / 2 - 1);
    localparam logic [CW-1:0] Full = CW'(ClksPerBit - 1);
    localparam logic [7:0] OpAdd  = 8'h01;
    localparam logic [7:0] OpEcho = 8'hEC;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
    typedef enum logic [2:0] {PK_OPCODE, PK_RSVD, PK_LEN_LO, PK_LEN_HI, PK_PAYLOAD, PK_RESULT} pk_state_e;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

    // Reset is asserted asynchronously but released on a clock edge.
    logic rst_s1_q, rst_s2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end

    rx_state_e rx_st_q, rx_st_d;
    logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic rx_pend_q, rx_pend_d, rx_vld_q, rx_vld_d;

    pk_state_e pk_st_q, pk_st_d;
    logic [7:0] op_q, op_d, len_lo_q, len_lo_d;
    logic [15:0] pay_q, pay_d, cnt_q, cnt_d, len_full, cnt_inc;
    logic [31:0] acc_q, acc_d;
    logic [1:0] ridx_q, ridx_d;
    logic push;
    logic [7:0] push_data;

    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [2:0] wp_q, wp_d, rp_q, rp_d, level;
    logic full, empty, pop;

    tx_state_e tx_st_q, tx_st_d;
    logic tx_q, tx_d;
    logic [8:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    assign len_full = {rx_data_q, len_lo_q};
    assign cnt_inc  = cnt_q + 16'd1;
    assign level    = wp_q - rp_q;
    assign full     = (level == 3'd4);
    assign empty    = (wp_q == rp_q);
    assign uart.tx_o = tx_q;

    // UART receiver: mid-bit sampling counted from the re-checked start bit.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_s1_d   = uart.rx_i;
        rx_s2_d   = rx_s1_q;
        rx_cnt_d  = rx_cnt_q + CW'(1);
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rx_pend_d = 1'b0;
        rx_vld_d  = rx_pend_q;
        unique case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == Half) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == Full) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == Full) begin
                if (rx_s2_q) begin
                    rx_pend_d = 1'b1;
                    rx_data_d = rx_sh_q;
                    rx_st_d   = RX_IDLE;
                end else begin
                    rx_st_d = RX_WAIT;  // framing error: drop byte, wait for idle line
                end
            end
            RX_WAIT: if (rx_s2_q) rx_st_d = RX_IDLE;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // Packet FSM. ADD accumulates byte-wise: adding each byte at its
    // little-endian position equals summing the zero-extended operands.
    always_comb begin
        pk_st_d   = pk_st_q;
        op_d      = op_q;
        len_lo_d  = len_lo_q;
        pay_d     = pay_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ridx_d    = ridx_q;
        push      = 1'b0;
        push_data = rx_data_q;
        unique case (pk_st_q)
            PK_OPCODE: begin
                acc_d  = '0;
                cnt_d  = '0;
                ridx_d = '0;
                if (rx_vld_q) begin
                    op_d    = rx_data_q;
                    pk_st_d = PK_RSVD;
                end
            end
            PK_RSVD: if (rx_vld_q) pk_st_d = PK_LEN_LO;
            PK_LEN_LO: if (rx_vld_q) begin
                len_lo_d = rx_data_q;
                pk_st_d  = PK_LEN_HI;
            end
            PK_LEN_HI: if (rx_vld_q) begin
                pay_d = (len_full > 16'd4) ? len_full - 16'd4 : 16'd0;
                if (len_full > 16'd4) pk_st_d = PK_PAYLOAD;
                else                  pk_st_d = (op_q == OpAdd) ? PK_RESULT : PK_OPCODE;
            end
            PK_PAYLOAD: if (rx_vld_q) begin
                cnt_d = cnt_inc;
                if (op_q == OpAdd)  acc_d = acc_q + (32'(rx_data_q) << {cnt_q[1:0], 3'b000});
                if (op_q == OpEcho) push = 1'b1;
                if (cnt_inc == pay_q) pk_st_d = (op_q == OpAdd) ? PK_RESULT : PK_OPCODE;
            end
            PK_RESULT: if (!full) begin
                push      = 1'b1;
                push_data = 8'(acc_q >> {ridx_q, 3'b000});
                ridx_d    = ridx_q + 2'd1;
                if (ridx_q == 2'd3) pk_st_d = PK_OPCODE;
            end
            default: pk_st_d = PK_OPCODE;
        endcase
    end

    // TX queue and UART transmitter; a push into a full queue is dropped.
    always_comb begin
        fifo_d   = fifo_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        tx_st_d  = tx_st_q;
        tx_d     = tx_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q + CW'(1);
        pop      = 1'b0;
        if (push && !full) begin
            fifo_d[wp_q[1:0]] = push_data;
            wp_d = wp_q + 3'd1;
        end
        unique case (tx_st_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!empty) pop = 1'b1;
            end
            TX_BUSY: if (tx_cnt_q == Full) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    if (!empty) pop = 1'b1;  // back-to-back frame, no idle gap
                    else begin
                        tx_st_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        if (pop) begin
            rp_d     = rp_q + 3'd1;
            tx_st_d  = TX_BUSY;
            tx_d     = 1'b0;
            tx_sh_d  = {1'b1, fifo_q[rp_q[1:0]]};
            tx_bit_d = '0;
            tx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            rx_st_q <= RX_IDLE;  rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;
            rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;  rx_data_q <= '0;
            rx_pend_q <= 1'b0;  rx_vld_q <= 1'b0;
            pk_st_q <= PK_OPCODE;  op_q <= '0;  len_lo_q <= '0;
            pay_q <= '0;  cnt_q <= '0;  acc_q <= '0;  ridx_q <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wp_q <= '0;  rp_q <= '0;
            tx_st_q <= TX_IDLE;  tx_q <= 1'b1;  tx_sh_q <= '1;
            tx_bit_q <= '0;  tx_cnt_q <= '0;
        end else begin
            rx_st_q <= rx_st_d;  rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;
            rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
            rx_data_q <= rx_data_d;  rx_pend_q <= rx_pend_d;  rx_vld_q <= rx_vld_d;
            pk_st_q <= pk_st_d;  op_q <= op_d;  len_lo_q <= len_lo_d;
            pay_q <= pay_d;  cnt_q <= cnt_d;  acc_q <= acc_d;  ridx_q <= ridx_d;
            fifo_q <= fifo_d;  wp_q <= wp_d;  rp_q <= rp_d;
            tx_st_q <= tx_st_d;  tx_q <= tx_d;  tx_sh_q <= tx_sh_d;
            tx_bit_q <= tx_bit_d;  tx_cnt_q <= tx_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_alu_top.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_top
// Purpose : drives packets into uart_alu_top over rx_i and decodes tx_o.
//           Expected TX bytes come from a packet-level model (plain
//           little-endian arithmetic on the payload) and are checked in
//           order by a UART-decoding monitor.
// ---------------------------------------------------------------------------
module tb_uart_alu_top;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    uart_alu_top_if u_if();

    uart_alu_top #(.ClksPerBit(CPB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .uart   (u_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    bit mon_busy = 1'b0;
    bit mon_en = 1'b1;
    logic [7:0] mon_b;
    logic mon_stop;
    logic [7:0] mon_e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        u_if.rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = b[i];
            repeat (CPB) tick();
        end
        u_if.rx_i = !bad_stop;
        repeat (CPB) tick();
        if (bad_stop) begin
            u_if.rx_i = 1'b1;
            repeat (CPB) tick();
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
        send_byte(op, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
    endtask

    // Model: payload as little-endian 32-bit words, last one zero-extended.
    function automatic logic [31:0] model_add();
        logic [31:0] s = 32'd0;
        logic [31:0] w;
        for (int i = 0; i < pay_q.size(); i += 4) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (i + k < pay_q.size()) w[8*k +: 8] = pay_q[i + k];
            s = s + w;
        end
        return s;
    endfunction

    // Model: bytes the processor must send for a packet with payload pay_q.
    task automatic expect_pkt(input logic [7:0] op);
        logic [31:0] s;
        if (op == 8'h01) begin
            s = model_add();
            for (int k = 0; k < 4; k++) exp_q.push_back(s[8*k +: 8]);
        end else if (op == 8'hEC) begin
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        end
    endtask

    task automatic run_pkt(input logic [7:0] op, input logic [15:0] len);
        expect_pkt(op);
        send_hdr(op, len);
        foreach (pay_q[i]) send_byte(pay_q[i], 1'b0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 4000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d bytes outstanding want 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (12 * CPB) tick();
    endtask

    // Monitor: decodes each tx_o frame at mid-bit and checks it in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni && u_if.tx_o === 1'b0) begin
                mon_busy = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = u_if.tx_o;
                end
                repeat (CPB) @(negedge clk);
                mon_stop = u_if.tx_o;
                if (mon_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_byte got %h (unexpected) want none", mon_b);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_b !== mon_e || mon_stop !== 1'b1) begin
                            errors++;
                            $display("FAIL tx_byte got %h stop %b want %h stop 1", mon_b, mon_stop, mon_e);
                        end
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        int n;
        u_if.rx_i = 1'b1;
        rst_ni = 1'b0;
        repeat (5) tick();
        check("reset_tx", 32'(u_if.tx_o), 32'd1);
        rst_ni = 1'b1;
        repeat (20) tick();
        check("idle_tx", 32'(u_if.tx_o), 32'd1);

        // Hand-computed pins for the model.
        pay_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        check("pin_add", model_add(), 32'h0000000C);
        pay_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        check("pin_wrap", model_add(), 32'h00000001);
        pay_q = '{8'h11, 8'h22, 8'h33};
        check("pin_partial", model_add(), 32'h00332211);
        pay_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
        check("pin_frame", model_add(), 32'h05000000);

        pay_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_pkt(8'h01, 16'd12);
        drain("add");

        pay_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt(8'h01, 16'd12);
        drain("wrap");

        pay_q.delete();
        for (int i = 0; i < 200; i++) pay_q.push_back(8'($urandom));
        run_pkt(8'h01, 16'd204);
        drain("random");

        pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_pkt(8'hEC, 16'd8);
        drain("echo");

        pay_q = '{8'hAA, 8'hBB};
        run_pkt(8'h55, 16'd6);
        pay_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt(8'h01, 16'd12);
        drain("unknown");

        pay_q.delete();
        run_pkt(8'h01, 16'd4);
        run_pkt(8'h01, 16'd2);
        drain("zero_ops");

        pay_q = '{8'h11, 8'h22, 8'h33};
        run_pkt(8'h01, 16'd7);
        drain("partial");

        // Stop bit of the first payload byte corrupted: the packet consumes
        // one extra byte and the sum sees the shifted stream.
        pay_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
        expect_pkt(8'h01);
        send_hdr(8'h01, 16'd12);
        send_byte(8'h01, 1'b1);
        foreach (pay_q[i]) send_byte(pay_q[i], 1'b0);
        drain("framing");

        // Reset while a frame is on tx_o: the line must go high without a clock edge.
        mon_en = 1'b0;
        send_hdr(8'hEC, 16'd5);
        send_byte(8'h00, 1'b0);
        n = 0;
        while (u_if.tx_o !== 1'b0 && n < 4 * CPB) begin
            tick();
            n++;
        end
        check("tx_started", 32'(u_if.tx_o), 32'd0);
        repeat (2 * CPB) tick();
        #3 rst_ni = 1'b0;
        #1 check("tx_async_reset", 32'(u_if.tx_o), 32'd1);
        repeat (5) tick();
        rst_ni = 1'b1;
        repeat (14 * CPB) tick();
        mon_en = 1'b1;

        // Reset in the middle of an ADD payload byte.
        send_hdr(8'h01, 16'd12);
        send_byte(8'h09, 1'b0);
        send_byte(8'h00, 1'b0);
        u_if.rx_i = 1'b0;
        repeat (3 * CPB) tick();
        #3 rst_ni = 1'b0;
        #1 check("reset_mid_add", 32'(u_if.tx_o), 32'd1);
        repeat (5) tick();
        u_if.rx_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (4 * CPB) tick();
        pay_q = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00};
        check("pin_after_reset", model_add(), 32'h0000001E);
        run_pkt(8'h01, 16'd12);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_alu_top.md
# uart_alu_top

Serial command processor: receives byte packets over a UART, executes the requested operation, and returns the result over a UART transmit line. It sits at the chip/FPGA pin boundary, directly behind the RX/TX pins. It contains a UART receiver, a UART transmitter, a small TX byte queue and a packet/ALU state machine. Supported operations are 32-bit wrapping add and echo.

## Interface
- `ClksPerBit`, default 410: clock cycles per UART bit (31.5 MHz / 76800 baud).
- `clk_i`  in  1  single system clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  UART receive line. 8N1, LSB first, idle high.
- `tx_o`  out  1  UART transmit line. 8N1, LSB first, idle high.

## Operation
- Packet format: byte0 opcode; byte1 reserved (value ignored); byte2 length LSB; byte3 length MSB; then the payload.
- Length is the total packet size in bytes, header included, so payload = length − 4. Any length < 4 is treated as 4 (no payload).
- Multi-byte values are little-endian.
- Opcode 0x01 ADD:
  - Payload is a list of 32-bit operands.
  - Sum is accumulated mod 2^32; overflow wraps silently.
  - If the payload is not a multiple of 4 bytes, the trailing partial operand is zero-extended.
  - After the last payload byte, the 4 sum bytes are queued to TX, LSB first.
  - Zero operands produce result 0.
- Opcode 0xEC ECHO: each payload byte is queued to TX as soon as it is received, in order.
- Any other opcode: the payload is counted and discarded; nothing is transmitted.
- Packet FSM states: OPCODE → RSVD → LEN_LO → LEN_HI → PAYLOAD (skipped if payload = 0) → RESULT (ADD only) → OPCODE.
  - The accumulator and byte counter clear on entry to OPCODE.
  - RESULT pushes the 4 result bytes when queue space allows, then returns to OPCODE.
- UART RX:
  - `rx_i` passes through a 2-FF synchronizer.
  - A falling edge in idle starts a frame. The start bit is re-sampled at ClksPerBit/2; if high, the frame is a glitch and RX returns to idle.
  - Data bits are sampled every ClksPerBit from mid-start.
  - A stop bit sampled low is a framing error: the byte is discarded and RX waits for the line to go high before re-arming.
- UART TX: start bit (0), 8 data bits LSB first, stop bit (1), each exactly ClksPerBit cycles. Frames may be sent back-to-back with no idle gap.
- TX queue: 4-entry FIFO between the FSM and TX.
  - Echo at equal baud never fills it.
  - A push when full drops the byte.
  - RESULT never drops; it stalls until space is available.

## Timing
- Reset (async assert, sync deassert internally): `tx_o`=1, FSM=OPCODE, FIFO empty, RX idle, accumulator=0.
- Reset mid-packet or mid-frame aborts everything. `tx_o` returns to 1 immediately, not at a clock edge.
- RX byte valid: 1-cycle pulse, 2 cycles after the stop-bit mid-sample.
- FSM consumes a byte in the cycle after valid; ADD accumulate completes in that same cycle.
- First result/echo start bit begins ≤ 3 cycles after the relevant byte-valid pulse, provided TX is idle.
- Otherwise TX pops the next FIFO entry in the cycle after the current stop bit ends.
- Bit-period tolerance: RX accepts a sender clock error of ±2 %.
- A new packet may start immediately after the last payload byte, while the result is still transmitting. RX and FSM operate independently of TX.

## Test plan
- ADD, length 12 (0x000C), operands 5 and 7 → `tx_o` frames 0C 00 00 00.
- ADD wrap: operands 0xFFFFFFFF and 0x00000002 → 01 00 00 00. Also 50 random operands → byte-exact mod-2^32 sum.
- ECHO, length 8, payload EF BE AD DE → frames EF BE AD DE in order. No other bytes are sent.
- Unknown opcode 0x55, length 6, payload AA BB, then ADD 1+2 → only 03 00 00 00 is transmitted.
- Framing error: corrupt the stop bit of one payload byte of an ADD packet → that byte is ignored. The packet completes one byte later, and the sum reflects the shifted byte stream.
- Assert `rst_ni` low mid-ADD payload and release → `tx_o`=1 during reset. A fresh ADD 10+20 then returns 1E 00 00 00.
